inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction-fetch stage that sits directly upstream of the decode stage, via the IF/ID register. It assembles each 32-bit instruction from four little-endian byte reads over the core's 8-bit memory port and arbitrates for that port with a single grant bit. It presents a (pc, instruction, valid) triple downstream, holds it under downstream stall, and flushes and redirects on a taken branch/jump from execute.

## Interface
- No parameters. Address and data widths are fixed: 32-bit PC/instruction, 8-bit memory data.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global run enable; low freezes all state
- stall_i  in  1  downstream cannot accept this cycle
- branch_i  in  1  redirect request from execute
- branch_addr_i  in  32  redirect target byte address
- mem_grant_i  in  1  memory port granted to fetch this cycle (combinational reply to mem_req_o)
- mem_din_i  in  8  byte read from memory, valid the cycle after a granted request
- mem_req_o  out  1  fetch requests the memory port
- mem_addr_o  out  32  byte address of the request
- pc_o  out  32  address of the presented instruction
- inst_o  out  32  presented instruction
- inst_valid_o  out  1  pc_o/inst_o hold a complete instruction

## Operation
- State:
  - pc: 32-bit, the current fetch address
  - issue_cnt: 0..4, bytes requested
  - recv_cnt: 0..3, bytes captured
  - pending: 1 bit, a byte is in flight
  - buf0..buf2: 8-bit byte buffers
  - output registers
- States:
  - FETCH: issue_cnt<4 or bytes outstanding
  - HOLD: inst_valid_o=1
- Request: mem_req_o = rdy & !rst & (state==FETCH) & (issue_cnt<4) & !branch_i.
- Address: mem_addr_o = pc + issue_cnt, 32-bit, wrapping.
- Granted request (mem_req_o & mem_grant_i): issue_cnt++ and pending<=1 for the next cycle. Otherwise pending<=0.
- Capture: when pending=1, mem_din_i is taken as byte recv_cnt.
  - Bytes 0–2 go to buf0–buf2, then recv_cnt++.
  - Byte 3: inst_o <= {mem_din_i, buf2, buf1, buf0}, pc_o <= pc, inst_valid_o <= 1, state -> HOLD.
- Issue and capture overlap in the same cycle: byte k+1 is issued while byte k is captured.
- HOLD with stall_i=1: all outputs held, no requests.
- HOLD with stall_i=0 (accept): inst_valid_o <= 0, pc <= pc+4, counters cleared, state -> FETCH.
- Grant low: no issue that cycle. Already-captured bytes are retained, and the same address is re-requested next cycle.
- Redirect when branch_i=1 and rdy=1, which overrides all other activity:
  - pc <= branch_addr_i
  - inst_valid_o <= 0
  - issue_cnt, recv_cnt, pending <= 0, so the in-flight byte is discarded next cycle
  - state -> FETCH
- branch_addr_i is used unmodified; no alignment check is made.
- rdy=0: no register changes and mem_req_o=0. Memory holds mem_din_i stable during the pause, so a pending byte is captured on the first rdy=1 cycle.

## Timing
- Reset (async, immediate) values:
  - pc, pc_o, inst_o, mem_addr_o: 0
  - inst_valid_o, mem_req_o: 0
  - counters and pending: 0
  - state: FETCH
- Latency with continuous grant:
  - Issues in cycles 0–3, captures in cycles 1–4.
  - inst_valid_o=1 in cycle 5.
- Accept in cycle N puts inst_valid_o=0 in N+1 and issues pc+4 in N+1. Throughput is 6 cycles per instruction with no stall.
- Branch in cycle N:
  - First new issue at N+1.
  - A capture due in N+1 is dropped.
  - Valid no earlier than N+6.
- Branch in the same cycle as the byte-3 capture: the branch wins, the instruction is not presented, and inst_valid_o stays 0.
- Branch in the same cycle as an accept: the branch wins, so pc = branch_addr_i, not pc+4.
- stall_i has no effect while in FETCH.
- Wrap-around: pc 0xFFFFFFFC accepted gives next pc 0x00000000. Byte addresses wrap modulo 2^32.
- Reset asserted mid-fetch: outputs go to reset values in the same cycle. Fetch restarts at 0 on the first edge after release.

## Test plan
- Basic fetch: reset, then rdy=1, grant=1, mem[0..3]=93 00 10 00.
  - mem_addr_o = 0,1,2,3 in cycles 0–3.
  - Cycle 5: inst_valid_o=1, inst_o=0x00100093, pc_o=0.
- Stall then accept: stall_i=1 for cycles 5–7.
  - Outputs are stable and mem_req_o=0 during the stall.
  - Release at 8; cycle 9 has valid=0 and mem_addr_o=4.
- Grant denial: mem_grant_i=0 in cycle 1.
  - Address 1 is re-requested in cycle 2.
  - inst_valid_o=1 in cycle 6 with the correct word.
- Redirect mid-fetch: branch_i=1 with branch_addr_i=0x100 in cycle 2.
  - The cycle-3 byte is discarded.
  - Issues 0x100–0x103 in cycles 3–6.
  - Valid in cycle 8, pc_o=0x100, word assembled from mem[0x100..0x103].
- Pause: rdy=0 in cycles 2–3.
  - mem_req_o=0 and no state change during the pause.
  - inst_valid_o=1 in cycle 7 with the correct word.
- Async reset in cycle 3: rst pulsed between edges.
  - All outputs are 0 immediately.
  - After release, fetch restarts at address 0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch: builds 32-bit little-endian words from four byte reads on the
// shared 8-bit memory port and presents (pc, inst, valid) to decode.
module inst_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        mem_grant_i,
    input  logic [7:0]  mem_din_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);
    typedef enum logic {FETCH, HOLD} state_t;

    state_t          state, state_nxt;
    logic [31:0]     pc, pc_nxt;
    logic [2:0]      issue_cnt, issue_nxt;
    logic [1:0]      recv_cnt, recv_nxt;
    logic            pending, pending_nxt;
    logic [2:0][7:0] buf_q, buf_nxt;
    logic [31:0]     pc_o_nxt, inst_nxt;
    logic            valid_nxt;

    assign mem_req_o  = rdy & ~rst & (state == FETCH) & (issue_cnt < 3'd4) & ~branch_i;
    assign mem_addr_o = pc + {29'd0, issue_cnt};

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        issue_nxt   = issue_cnt;
        recv_nxt    = recv_cnt;
        pending_nxt = 1'b0;
        buf_nxt     = buf_q;
        pc_o_nxt    = pc_o;
        inst_nxt    = inst_o;
        valid_nxt   = inst_valid_o;
        if (branch_i) begin
            // Redirect drops any in-flight byte by clearing pending.
            pc_nxt    = branch_addr_i;
            valid_nxt = 1'b0;
            issue_nxt = 3'd0;
            recv_nxt  = 2'd0;
            state_nxt = FETCH;
        end else if (state == HOLD) begin
            if (!stall_i) begin
                valid_nxt = 1'b0;
                pc_nxt    = pc + 32'd4;
                issue_nxt = 3'd0;
                recv_nxt  = 2'd0;
                state_nxt = FETCH;
            end
        end else begin
            if (mem_req_o && mem_grant_i) begin
                issue_nxt   = issue_cnt + 3'd1;
                pending_nxt = 1'b1;
            end
            if (pending) begin
                case (recv_cnt)
                    2'd0: begin buf_nxt[0] = mem_din_i; recv_nxt = 2'd1; end
                    2'd1: begin buf_nxt[1] = mem_din_i; recv_nxt = 2'd2; end
                    2'd2: begin buf_nxt[2] = mem_din_i; recv_nxt = 2'd3; end
                    default: begin
                        inst_nxt  = {mem_din_i, buf_q[2], buf_q[1], buf_q[0]};
                        pc_o_nxt  = pc;
                        valid_nxt = 1'b1;
                        state_nxt = HOLD;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= FETCH;
            pc           <= 32'd0;
            issue_cnt    <= 3'd0;
            recv_cnt     <= 2'd0;
            pending      <= 1'b0;
            buf_q        <= '0;
            pc_o         <= 32'd0;
            inst_o       <= 32'd0;
            inst_valid_o <= 1'b0;
        end else if (rdy) begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            issue_cnt    <= issue_nxt;
            recv_cnt     <= recv_nxt;
            pending      <= pending_nxt;
            buf_q        <= buf_nxt;
            pc_o         <= pc_o_nxt;
            inst_o       <= inst_nxt;
            inst_valid_o <= valid_nxt;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: byte memory model plus a scoreboard of expected (pc, inst) pairs.
module tb_inst_fetch;
    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b0, stall_i = 1'b0, branch_i = 1'b0;
    logic        mem_grant_i = 1'b0;
    logic [31:0] branch_addr_i = 32'd0;
    logic [7:0]  mem_din_i = 8'd0;
    logic        mem_req_o, inst_valid_o;
    logic [31:0] mem_addr_o, pc_o, inst_o;

    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
    exp_t sb[$];
    exp_t e;
    int n_vec = 0, n_err = 0;
    logic [7:0] mem [0:511];

    inst_fetch dut (
        .clk(clk), .rst(rst), .rdy(rdy), .stall_i(stall_i), .branch_i(branch_i),
        .branch_addr_i(branch_addr_i), .mem_grant_i(mem_grant_i), .mem_din_i(mem_din_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .pc_o(pc_o), .inst_o(inst_o),
        .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    // Memory answers a granted request one cycle later and otherwise holds its data.
    always @(posedge clk)
        if (mem_req_o && mem_grant_i) mem_din_i <= mem[mem_addr_o[8:0]];

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [8:0] i;
        i = a[8:0];
        return {mem[9'(i + 9'd3)], mem[9'(i + 9'd2)], mem[9'(i + 9'd1)], mem[i]};
    endfunction

    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] ba,
                       input logic g);
        @(posedge clk); #1;
        rdy = r; stall_i = s; branch_i = b; branch_addr_i = ba; mem_grant_i = g;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; rdy = 1'b0; stall_i = 1'b0; branch_i = 1'b0; mem_grant_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic pop_check(input string name);
        n_vec++;
        if (sb.size() == 0) begin
            n_err++; $display("FAIL %s: valid=%b with empty scoreboard", name, inst_valid_o);
        end else begin
            e = sb.pop_front();
            if (inst_valid_o !== 1'b1 || pc_o !== e.pc || inst_o !== e.inst) begin
                n_err++;
                $display("FAIL %s: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                         name, inst_valid_o, pc_o, inst_o, e.pc, e.inst);
            end
        end
    endtask

    task automatic test_reset();
        #2; rdy = 1'b1; mem_grant_i = 1'b1; #1;
        n_vec++;
        if ({inst_valid_o, mem_req_o, pc_o, inst_o, mem_addr_o} !== 98'd0) begin
            n_err++; $display("FAIL reset: got v=%b req=%b pc=%h inst=%h addr=%h want all 0",
                              inst_valid_o, mem_req_o, pc_o, inst_o, mem_addr_o);
        end
    endtask

    task automatic test_fetch_stall();
        do_reset();
        sb.push_back('{32'h0, word(32'h0)});
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 0, 0, 1);
            n_vec++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== k) begin
                n_err++; $display("FAIL fetch_addr%0d: got req=%b addr=%h want req=1 addr=%h",
                                  k, mem_req_o, mem_addr_o, k);
            end
        end
        cyc(1, 0, 0, 0, 1);
        n_vec++;
        if (mem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin
            n_err++; $display("FAIL fetch_c4: got req=%b v=%b want 0 0", mem_req_o, inst_valid_o);
        end
        cyc(1, 1, 0, 0, 1);
        pop_check("fetch_c5");
        n_vec++;
        if (inst_o !== 32'h00100093) begin
            n_err++; $display("FAIL fetch_word: got %h want 00100093", inst_o);
        end
        for (int k = 6; k < 9; k++) begin
            cyc(1, (k < 8), 0, 0, 1);
            n_vec++;
            if (inst_valid_o !== 1'b1 || pc_o !== e.pc || inst_o !== e.inst || mem_req_o !== 1'b0) begin
                n_err++; $display("FAIL stall_c%0d: got v=%b pc=%h inst=%h req=%b want v=1 pc=%h inst=%h req=0",
                                  k, inst_valid_o, pc_o, inst_o, mem_req_o, e.pc, e.inst);
            end
        end
        cyc(1, 0, 0, 0, 1);
        sb.push_back('{32'h4, word(32'h4)});
        n_vec++;
        if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h4) begin
            n_err++; $display("FAIL accept_c9: got v=%b req=%b addr=%h want v=0 req=1 addr=4",
                              inst_valid_o, mem_req_o, mem_addr_o);
        end
        for (int k = 10; k < 14; k++) cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        pop_check("back_to_back_c14");
    endtask

    task automatic test_grant_deny();
        do_reset();
        sb.push_back('{32'h0, word(32'h0)});
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1);
        n_vec++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1) begin
            n_err++; $display("FAIL deny_rereq: got req=%b addr=%h want req=1 addr=1", mem_req_o, mem_addr_o);
        end
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        n_vec++;
        if (inst_valid_o !== 1'b0) begin
            n_err++; $display("FAIL deny_c5: got v=%b want 0", inst_valid_o);
        end
        cyc(1, 1, 0, 0, 1);
        pop_check("deny_c6");
    endtask

    task automatic test_redirect();
        do_reset();
        sb.push_back('{32'h100, word(32'h100)});
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 1, 32'h100, 1);
        n_vec++;
        if (mem_req_o !== 1'b0) begin
            n_err++; $display("FAIL redir_c2: got req=%b want 0", mem_req_o);
        end
        for (int k = 3; k < 7; k++) begin
            cyc(1, 0, 0, 0, 1);
            n_vec++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 + k - 3) begin
                n_err++; $display("FAIL redir_addr_c%0d: got req=%b addr=%h want req=1 addr=%h",
                                  k, mem_req_o, mem_addr_o, 32'h100 + k - 3);
            end
        end
        cyc(1, 0, 0, 0, 1);
        n_vec++;
        if (inst_valid_o !== 1'b0) begin
            n_err++; $display("FAIL redir_c7: got v=%b want 0", inst_valid_o);
        end
        // Accept and branch together: the branch target must win over pc+4.
        cyc(1, 0, 1, 32'h200, 1);
        pop_check("redir_c8");
        cyc(1, 0, 0, 0, 1);
        n_vec++;
        if (inst_valid_o !== 1'b0 || mem_addr_o !== 32'h200 || mem_req_o !== 1'b1) begin
            n_err++; $display("FAIL branch_accept: got v=%b req=%b addr=%h want v=0 req=1 addr=200",
                              inst_valid_o, mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_pause();
        do_reset();
        sb.push_back('{32'h0, word(32'h0)});
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        for (int k = 2; k < 4; k++) begin
            cyc(0, 0, 0, 0, 1);
            n_vec++;
            if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h2 || inst_valid_o !== 1'b0) begin
                n_err++; $display("FAIL pause_c%0d: got req=%b addr=%h v=%b want req=0 addr=2 v=0",
                                  k, mem_req_o, mem_addr_o, inst_valid_o);
            end
        end
        cyc(1, 0, 0, 0, 1);
        n_vec++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h2) begin
            n_err++; $display("FAIL pause_resume: got req=%b addr=%h want req=1 addr=2", mem_req_o, mem_addr_o);
        end
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        pop_check("pause_c7");
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 1);
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if ({inst_valid_o, mem_req_o, pc_o, inst_o, mem_addr_o} !== 98'd0) begin
            n_err++; $display("FAIL async_rst: got v=%b req=%b pc=%h inst=%h addr=%h want all 0",
                              inst_valid_o, mem_req_o, pc_o, inst_o, mem_addr_o);
        end
        #1 rst = 1'b0;
        #1;
        sb.push_back('{32'h0, word(32'h0)});
        n_vec++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            n_err++; $display("FAIL async_restart: got req=%b addr=%h want req=1 addr=0", mem_req_o, mem_addr_o);
        end
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        pop_check("async_refetch");
    endtask

    task automatic test_wrap();
        do_reset();
        cyc(1, 0, 1, 32'hFFFF_FFFC, 1);
        sb.push_back('{32'hFFFF_FFFC, word(32'hFFFF_FFFC)});
        for (int k = 1; k < 5; k++) begin
            cyc(1, 0, 0, 0, 1);
            n_vec++;
            if (mem_addr_o !== 32'hFFFF_FFFB + k) begin
                n_err++; $display("FAIL wrap_addr_c%0d: got %h want %h", k, mem_addr_o, 32'hFFFF_FFFB + k);
            end
        end
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        pop_check("wrap_c6");
        cyc(1, 0, 0, 0, 1);
        n_vec++;
        if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h0) begin
            n_err++; $display("FAIL wrap_next: got v=%b req=%b addr=%h want v=0 req=1 addr=0",
                              inst_valid_o, mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_branch_capture();
        do_reset();
        for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 1, 32'h40, 1);
        sb.push_back('{32'h40, word(32'h40)});
        cyc(1, 0, 0, 0, 1);
        n_vec++;
        if (inst_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h40) begin
            n_err++; $display("FAIL br_capture_c5: got v=%b req=%b addr=%h want v=0 req=1 addr=40",
                              inst_valid_o, mem_req_o, mem_addr_o);
        end
        for (int k = 6; k < 10; k++) cyc(1, 0, 0, 0, 1);
        cyc(1, 1, 0, 0, 1);
        pop_check("br_capture_c10");
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h93; mem[1] = 8'h00; mem[2] = 8'h10; mem[3] = 8'h00;
        test_reset();
        test_fetch_stall();
        test_grant_deny();
        test_redirect();
        test_pause();
        test_async_reset();
        test_wrap();
        test_branch_capture();
        n_vec++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
